// File: rtl/sdram_xn_retimer.sv
// Purpose : retimes fast SDRAM-core handshakes into stable system-cycle levels and
//           queues read beats per channel; generates the core's once-per-system-cycle enable.
// Latency : 1 fast cycle minimum (core_ready on the update cycle), (queue pos+1)*RATIO maximum.
// Backpressure: none upstream; beats beyond DEPTH queued entries are dropped (overflow).
//
// Ports:
//   clk, resetn            fast clock, async active-low reset
//   align                  pulse after a system-clock edge; restarts the phase counter
//   core_ce                update-cycle enable to the core (combinational from phase)
//   core_busy/ack/ready/dout/bdone   raw fast-domain core outputs
//   busy/ack/ready/dout/burst_done   system-cycle-stable outputs
//   overflow               sticky per-channel drop flag
// Optional feature macro: SDRAM_XN_OVF_CHECK_EN (sticky overflow reporting; tied to 0 otherwise)
module sdram_xn_retimer #(
    parameter int NCH   = 3,
    parameter int RATIO = 2,
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              align,
    output logic              core_ce,
    input  logic              core_busy,
    input  logic [NCH-1:0]    core_ack,
    input  logic [NCH-1:0]    core_ready,
    input  logic [NCH*DW-1:0] core_dout,
    input  logic [NCH-1:0]    core_bdone,
    output logic              busy,
    output logic [NCH-1:0]    ack,
    output logic [NCH-1:0]    ready,
    output logic [NCH*DW-1:0] dout,
    output logic [NCH-1:0]    burst_done,
    output logic [NCH-1:0]    overflow
);
    localparam int PW = $clog2(RATIO);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PW-1:0]  r_ph;
    logic           w_upd;
    logic           r_busy;
    logic [NCH-1:0] r_ack;

    assign w_upd   = (r_ph == PW'(RATIO - 1));
    assign core_ce = w_upd;
    assign busy    = r_busy;
    assign ack     = r_ack;

    // align lands the next update cycle RATIO-1 cycles after the pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ph <= '0;
        end else if (align) begin
            r_ph <= PW'(1);
        end else if (w_upd) begin
            r_ph <= '0;
        end else begin
            r_ph <= r_ph + PW'(1);
        end
    end

    // the core only accepts requests while core_ce is high, so sampling on upd is enough
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy <= 1'b0;
            r_ack  <= '0;
        end else if (w_upd) begin
            r_busy <= core_busy;
            r_ack  <= core_ack;
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [DW-1:0] r_mem [DEPTH];
        logic [AW-1:0] r_rd;
        logic [AW-1:0] r_wr;
        logic [CW-1:0] r_cnt;
        logic [2:0]    r_bpend;
        logic [DW-1:0] r_dout;
        logic          r_rdy;
        logic          r_bd;
        logic [DW-1:0] w_din;
        logic          w_pop;
        logic          w_byp;
        logic          w_push_req;
        logic          w_full;
        logic          w_push;
        logic [CW-1:0] w_cnt_nxt;
        logic [2:0]    w_bpend_inc;
        logic          w_bd_fire;
        logic          w_ovf;

        assign w_din      = core_dout[ch*DW +: DW];
        assign w_pop      = w_upd && (r_cnt != '0);
        // an empty queue on the update cycle lets the arriving beat skip storage
        assign w_byp      = w_upd && (r_cnt == '0) && core_ready[ch];
        assign w_push_req = core_ready[ch] && !w_byp;
        assign w_full     = (r_cnt == CW'(DEPTH));
        // a full queue still takes a word when a pop frees a slot on the same edge
        assign w_push     = w_push_req && (!w_full || w_pop);
        assign w_cnt_nxt  = r_cnt + CW'(w_push) - CW'(w_pop);

        assign w_bpend_inc = (core_bdone[ch] && (r_bpend != 3'd7)) ? r_bpend + 3'd1 : r_bpend;
        // burst_done waits until the last beat of the burst has left the queue
        assign w_bd_fire   = w_upd && (w_bpend_inc != 3'd0) && (w_cnt_nxt == '0);

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr] <= w_din;
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_cnt   <= '0;
                r_bpend <= '0;
                r_dout  <= '0;
                r_rdy   <= 1'b0;
                r_bd    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr <= r_wr + AW'(1);
                end
                if (w_pop) begin
                    r_rd <= r_rd + AW'(1);
                end
                r_cnt   <= w_cnt_nxt;
                r_bpend <= w_bd_fire ? (w_bpend_inc - 3'd1) : w_bpend_inc;
                if (w_upd) begin
                    r_rdy <= w_pop || w_byp;
                    r_bd  <= w_bd_fire;
                    if (w_pop) begin
                        r_dout <= r_mem[r_rd];
                    end else if (w_byp) begin
                        r_dout <= w_din;
                    end
                end
            end
        end

`ifdef SDRAM_XN_OVF_CHECK_EN
        logic w_drop;
        logic r_ovf;

        assign w_drop = w_push_req && w_full && !w_pop;

        // a drop needs no extra burst_done handling: pending completions fire as soon
        // as the queue drains, so the requester cannot hang waiting on the lost word
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_ovf <= 1'b0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
        assign w_ovf = r_ovf;
`else
        assign w_ovf = 1'b0;
`endif

        assign ready[ch]           = r_rdy;
        assign burst_done[ch]      = r_bd;
        assign overflow[ch]        = w_ovf;
        assign dout[ch*DW +: DW]   = r_dout;
    end

endmodule

// File: tb/tb_sdram_xn_retimer.sv
// Purpose : randomized + directed bench for sdram_xn_retimer against a queue-based model.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
module tb_sdram_xn_retimer;
    localparam int NCH   = 3;
    localparam int RATIO = 2;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
`ifdef SDRAM_XN_OVF_CHECK_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetn;
    logic              align;
    logic              core_ce;
    logic              core_busy;
    logic [NCH-1:0]    core_ack;
    logic [NCH-1:0]    core_ready;
    logic [NCH*DW-1:0] core_dout;
    logic [NCH-1:0]    core_bdone;
    logic              busy;
    logic [NCH-1:0]    ack;
    logic [NCH-1:0]    ready;
    logic [NCH*DW-1:0] dout;
    logic [NCH-1:0]    burst_done;
    logic [NCH-1:0]    overflow;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    sdram_xn_retimer #(.NCH(NCH), .RATIO(RATIO), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .resetn(resetn), .align(align), .core_ce(core_ce),
        .core_busy(core_busy), .core_ack(core_ack), .core_ready(core_ready),
        .core_dout(core_dout), .core_bdone(core_bdone), .busy(busy), .ack(ack),
        .ready(ready), .dout(dout), .burst_done(burst_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int                m_ph;
    logic [DW-1:0]     mq [NCH][$];
    int                m_pend [NCH];
    logic [NCH-1:0]    m_ready, m_bd, m_ovf, m_ack;
    logic              m_busy;
    logic [NCH*DW-1:0] m_dout;
    logic [DW-1:0]     md;
    bit                mu;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_ph = 0;
            for (int c = 0; c < NCH; c++) begin
                mq[c].delete();
                m_pend[c] = 0;
            end
            m_ready = '0; m_bd = '0; m_ovf = '0; m_ack = '0; m_busy = 1'b0; m_dout = '0;
        end else begin
            mu = (m_ph == RATIO - 1);
            m_ph = align ? 1 : (m_ph + 1) % RATIO;
            for (int c = 0; c < NCH; c++) begin
                md = core_dout[c*DW +: DW];
                if (mu) begin
                    if (mq[c].size() > 0) begin
                        m_dout[c*DW +: DW] = mq[c].pop_front();
                        m_ready[c] = 1'b1;
                        if (core_ready[c]) mq[c].push_back(md);
                    end else if (core_ready[c]) begin
                        m_dout[c*DW +: DW] = md;
                        m_ready[c] = 1'b1;
                    end else begin
                        m_ready[c] = 1'b0;
                    end
                end else if (core_ready[c]) begin
                    if (mq[c].size() < DEPTH) mq[c].push_back(md);
                    else if (OVF_ON) m_ovf[c] = 1'b1;
                end
                if (core_bdone[c] && m_pend[c] < 7) m_pend[c]++;
                if (mu) begin
                    if (m_pend[c] > 0 && mq[c].size() == 0) begin
                        m_bd[c] = 1'b1;
                        m_pend[c]--;
                    end else begin
                        m_bd[c] = 1'b0;
                    end
                end
            end
            if (mu) begin
                m_busy = core_busy;
                m_ack  = core_ack;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            n_tests++;
            if (core_ce !== (m_ph == RATIO - 1) || busy !== m_busy || ack !== m_ack ||
                ready !== m_ready || dout !== m_dout || burst_done !== m_bd || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL cycle-compare t=%0t (got/expected): ce %b/%b busy %b/%b ack %b/%b ready %b/%b bd %b/%b ovf %b/%b dout %h/%h",
                         $time, core_ce, (m_ph == RATIO - 1), busy, m_busy, ack, m_ack, ready, m_ready,
                         burst_done, m_bd, overflow, m_ovf, dout, m_dout);
            end
        end
    end

    // ---------------- channel-0 log of each update edge ----------------
    typedef struct packed { logic r; logic [DW-1:0] d; logic b; } ent_t;
    ent_t lg[$];
    logic prev_ce;
    always @(negedge clk) begin
        if (prev_ce === 1'b1) lg.push_back('{ready[0], dout[DW-1:0], burst_done[0]});
        prev_ce = core_ce;
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic sync_upd();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (core_ce === 1'b1) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL sync_upd: core_ce never rose within 8 cycles");
    endtask

    task automatic check_log(input string nm, input int idx, input logic r, input logic [DW-1:0] d, input logic b);
        if (lg.size() <= idx) begin
            check({nm, " log-size"}, 64'(lg.size()), 64'(idx + 1));
        end else begin
            check(nm, {31'd0, lg[idx].r, lg[idx].d}, {31'd0, r, d});
            check({nm, " bd"}, 64'(lg[idx].b), 64'(b));
        end
    endtask

    task automatic clear_inputs();
        align = 1'b0; core_busy = 1'b0; core_ack = '0; core_ready = '0; core_dout = '0; core_bdone = '0;
    endtask

    logic [DW-1:0] ovf_exp [10] = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17, 32'd18, 32'd20};
    logic any_out;

    initial begin
        resetn = 1'b0;
        clear_inputs();
        cmp_en = 1'b1;
        repeat (3) tick();
        check("reset outputs", {busy, ack, ready, burst_done, overflow, core_ce}, '0);
        check("reset dout", 64'(dout[63:0]), 64'd0);
        resetn = 1'b1;
        repeat (4) tick();

        // single beat on the update cycle: bypass, two fast cycles of ready
        sync_upd();
        lg.delete();
        core_ready[0] = 1'b1; core_dout[DW-1:0] = 32'hDEADBEEF;
        tick();
        core_ready[0] = 1'b0;
        check("bypass ready c1", {ready[0], dout[DW-1:0]}, {1'b1, 32'hDEADBEEF});
        tick();
        check("bypass ready c2", 64'(ready[0]), 64'd1);
        tick();
        check("bypass ready c3", 64'(ready[0]), 64'd0);
        repeat (4) tick();
        check_log("bypass log0", 0, 1'b1, 32'hDEADBEEF, 1'b0);
        check_log("bypass no-push", 1, 1'b0, 32'hDEADBEEF, 1'b0);

        // burst 1..4 then bdone
        sync_upd();
        lg.delete();
        for (int i = 1; i <= 4; i++) begin
            core_ready[0] = 1'b1; core_dout[DW-1:0] = DW'(i);
            tick();
        end
        core_ready[0] = 1'b0; core_bdone[0] = 1'b1;
        tick();
        core_bdone[0] = 1'b0;
        repeat (12) tick();
        for (int i = 0; i < 4; i++) check_log("burst beat", i, 1'b1, DW'(i + 1), (i == 3));
        check_log("burst end", 4, 1'b0, 32'd4, 1'b0);

        // 12 back-to-back beats overflow a 4-entry queue at RATIO=2
        sync_upd();
        lg.delete();
        for (int i = 0; i < 12; i++) begin
            core_ready[0] = 1'b1; core_dout[DW-1:0] = DW'(10 + i);
            tick();
        end
        core_ready[0] = 1'b0; core_bdone[0] = 1'b1;
        tick();
        core_bdone[0] = 1'b0;
        check("overflow flag", 64'(overflow[0]), 64'(OVF_ON));
        repeat (30) tick();
        for (int i = 0; i < 10; i++) check_log("ovf beat", i, 1'b1, ovf_exp[i], (i == 9));
        check_log("ovf end", 10, 1'b0, 32'd20, 1'b0);

        // align mid-stream with two beats queued
        sync_upd();
        lg.delete();
        for (int i = 0; i < 4; i++) begin
            core_ready[0] = 1'b1; core_dout[DW-1:0] = DW'(30 + i);
            tick();
        end
        core_ready[0] = 1'b0; align = 1'b1;
        tick();
        align = 1'b0;
        check("align ce", 64'(core_ce), 64'd1);
        repeat (10) tick();
        for (int i = 0; i < 4; i++) check_log("align beat", i, 1'b1, DW'(30 + i), 1'b0);
        check_log("align end", 4, 1'b0, 32'd33, 1'b0);

        // three channels on the same cycle
        sync_upd();
        core_ready = '1;
        core_dout = {32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
        tick();
        core_ready = '0;
        check("3ch ready", 64'(ready), 64'h7);
        check("3ch dout0", 64'(dout[31:0]), 64'hA0A0_0001);
        check("3ch dout1", 64'(dout[63:32]), 64'hB0B0_0002);
        check("3ch dout2", 64'(dout[95:64]), 64'hC0C0_0003);
        repeat (6) tick();

        // reset with beats queued and burst_done pending
        sync_upd();
        for (int i = 0; i < 6; i++) begin
            core_ready[0] = 1'b1; core_dout[DW-1:0] = DW'(40 + i);
            core_bdone[0] = (i == 5);
            tick();
        end
        core_ready[0] = 1'b0; core_bdone[0] = 1'b0;
        resetn = 1'b0;
        #1;
        check("midreset outputs", {busy, ack, ready, burst_done, core_ce}, '0);
        check("midreset dout0", 64'(dout[DW-1:0]), 64'd0);
        repeat (3) tick();
        resetn = 1'b1;
        lg.delete();
        repeat (12) tick();
        any_out = 1'b0;
        foreach (lg[i]) any_out |= lg[i].r | lg[i].b;
        check("post-reset silent", 64'(any_out), 64'd0);
        check("post-reset log len", 64'(lg.size() >= 5), 64'd1);

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < NCH; c++) begin
                core_ready[c] = ($urandom_range(0, 9) < 4);
                core_dout[c*DW +: DW] = $urandom;
                core_bdone[c] = ($urandom_range(0, 19) == 0);
            end
            core_ack  = NCH'($urandom);
            core_busy = 1'($urandom);
            align     = ($urandom_range(0, 49) == 0);
            tick();
        end
        clear_inputs();
        repeat (30) tick();

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
